// File: rtl/chacha20_arbiter.sv
// chacha20_arbiter: shares one chacha20_encrypt core between two message requesters,
// with a fair tie-break and a no-progress watchdog that aborts and resets the core.
//
// state  | meaning
// IDLE   | no message in flight; arbitrate requests
// START  | core_start pulse, watchdog cleared
// STREAM | byte streams routed between the granted requester and the core
// ABORT  | watchdog expired; core held in reset, done+error pulsed
module chacha20_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         r0_req,
   input  logic [255:0] r0_key,
   input  logic [95:0]  r0_nonce,
   input  logic [31:0]  r0_counter,
   input  logic [7:0]   r0_pt_data,
   input  logic         r0_pt_valid,
   input  logic         r0_pt_last,
   output logic         r0_pt_ready,
   output logic [7:0]   r0_ct_data,
   output logic         r0_ct_valid,
   output logic         r0_ct_last,
   input  logic         r0_ct_ready,
   output logic         r0_done,
   output logic         r0_error,
   input  logic         r1_req,
   input  logic [255:0] r1_key,
   input  logic [95:0]  r1_nonce,
   input  logic [31:0]  r1_counter,
   input  logic [7:0]   r1_pt_data,
   input  logic         r1_pt_valid,
   input  logic         r1_pt_last,
   output logic         r1_pt_ready,
   output logic [7:0]   r1_ct_data,
   output logic         r1_ct_valid,
   output logic         r1_ct_last,
   input  logic         r1_ct_ready,
   output logic         r1_done,
   output logic         r1_error,
   output logic [1:0]   gnt,
   output logic         busy,
   output logic         core_start,
   output logic [255:0] core_key,
   output logic [95:0]  core_nonce,
   output logic [31:0]  core_counter,
   output logic [7:0]   core_pt_data,
   output logic         core_pt_valid,
   output logic         core_pt_last,
   input  logic         core_pt_ready,
   input  logic [7:0]   core_ct_data,
   input  logic         core_ct_valid,
   input  logic         core_ct_last,
   output logic         core_ct_ready,
   input  logic         core_done,
   output logic         core_rst_n
);

   typedef enum logic [1:0] {IDLE, START, STREAM, ABORT} state_t;

   localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] WD_LAST = TIMEOUT_CYCLES - 1;

   state_t         state_q, state_d;
   logic [1:0]     gnt_q, gnt_d;
   logic           last_gnt_q, last_gnt_d;
   logic [255:0]   key_q, key_d;
   logic [95:0]    nonce_q, nonce_d;
   logic [31:0]    counter_q, counter_d;
   logic [31:0]    wd_q, wd_d;
   logic [1:0]     done_q, done_d;
   logic [1:0]     error_q, error_d;
   logic           core_rst_n_q, core_rst_n_d;
   logic           pick_r1;
   logic           pt_beat, ct_beat, wd_expire;

   // stream routing is purely combinational; only the granted side sees the core
   always_comb begin
      core_pt_data  = '0;
      core_pt_valid = 1'b0;
      core_pt_last  = 1'b0;
      core_ct_ready = 1'b1;
      r0_pt_ready   = 1'b0;
      r0_ct_data    = '0;
      r0_ct_valid   = 1'b0;
      r0_ct_last    = 1'b0;
      r1_pt_ready   = 1'b0;
      r1_ct_data    = '0;
      r1_ct_valid   = 1'b0;
      r1_ct_last    = 1'b0;
      if (state_q == STREAM) begin
         if (gnt_q[0]) begin
            core_pt_data  = r0_pt_data;
            core_pt_valid = r0_pt_valid;
            core_pt_last  = r0_pt_last;
            r0_pt_ready   = core_pt_ready;
            r0_ct_data    = core_ct_data;
            r0_ct_valid   = core_ct_valid;
            r0_ct_last    = core_ct_last;
            core_ct_ready = r0_ct_ready;
         end else if (gnt_q[1]) begin
            core_pt_data  = r1_pt_data;
            core_pt_valid = r1_pt_valid;
            core_pt_last  = r1_pt_last;
            r1_pt_ready   = core_pt_ready;
            r1_ct_data    = core_ct_data;
            r1_ct_valid   = core_ct_valid;
            r1_ct_last    = core_ct_last;
            core_ct_ready = r1_ct_ready;
         end
      end
   end

   assign pt_beat   = core_pt_valid & core_pt_ready;
   assign ct_beat   = core_ct_valid & core_ct_ready;
   assign wd_expire = WD_EN && !(pt_beat || ct_beat) && (wd_q >= WD_LAST);

   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      last_gnt_d   = last_gnt_q;
      key_d        = key_q;
      nonce_d      = nonce_q;
      counter_d    = counter_q;
      wd_d         = wd_q;
      done_d       = 2'b00;
      error_d      = 2'b00;
      core_rst_n_d = 1'b1;
      // on a tie, serve whoever was not served last
      pick_r1      = r1_req & (~r0_req | ~last_gnt_q);
      case (state_q)
         IDLE: begin
            if (r0_req | r1_req) begin
               gnt_d     = pick_r1 ? 2'b10 : 2'b01;
               key_d     = pick_r1 ? r1_key : r0_key;
               nonce_d   = pick_r1 ? r1_nonce : r0_nonce;
               counter_d = pick_r1 ? r1_counter : r0_counter;
               state_d   = START;
            end
         end
         START: begin
            wd_d    = '0;
            state_d = STREAM;
         end
         STREAM: begin
            if (core_done) begin
               done_d     = gnt_q;
               last_gnt_d = gnt_q[1];
               gnt_d      = 2'b00;
               state_d    = IDLE;
            end else if (wd_expire) begin
               done_d       = gnt_q;
               error_d      = gnt_q;
               core_rst_n_d = 1'b0;
               state_d      = ABORT;
            end else if (pt_beat || ct_beat) begin
               wd_d = '0;
            end else if (wd_q != 32'hFFFF_FFFF) begin
               wd_d = wd_q + 32'd1;
            end
         end
         ABORT: begin
            last_gnt_d = gnt_q[1];
            gnt_d      = 2'b00;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         gnt_q        <= 2'b00;
         last_gnt_q   <= 1'b1;
         key_q        <= '0;
         nonce_q      <= '0;
         counter_q    <= '0;
         wd_q         <= '0;
         done_q       <= 2'b00;
         error_q      <= 2'b00;
         core_rst_n_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         last_gnt_q   <= last_gnt_d;
         key_q        <= key_d;
         nonce_q      <= nonce_d;
         counter_q    <= counter_d;
         wd_q         <= wd_d;
         done_q       <= done_d;
         error_q      <= error_d;
         core_rst_n_q <= core_rst_n_d;
      end
   end

   assign gnt          = gnt_q;
   assign busy         = (state_q != IDLE);
   assign core_start   = (state_q == START);
   assign core_key     = key_q;
   assign core_nonce   = nonce_q;
   assign core_counter = counter_q;
   assign core_rst_n   = core_rst_n_q;
   assign r0_done      = done_q[0];
   assign r1_done      = done_q[1];
   assign r0_error     = error_q[0];
   assign r1_error     = error_q[1];

endmodule
